op_sequencer: RTL and testbench
===============================

# op_sequencer

Controller that sequences one shared processing engine on behalf of a host. It accepts a host request and launches the engine. It watches for completion, abort, error or timeout, retries errored operations with an enable holdoff, and reports a status code. It sits between the host request/ack interface and the engine's START/ENABLE/ENDD/ER handshake.

## Interface
- MAX_RETRY, 3: retries allowed after ER before giving up (0..7).
- TIMEOUT, 255: BUSY cycles without ENDD/ER/STOP before timeout (1..2^CNT_W-1).
- CNT_W, 8: timeout counter width.
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- REQ  in  1  host request, level, held until ACK.
- ACK  out  1  one-cycle pulse: request accepted.
- RDY  out  1  high only in IDLE.
- START  out  1  one-cycle launch pulse to engine, on every attempt.
- ENABLE  out  1  engine enable.
- ENDD  in  1  engine finished OK; sampled only in BUSY.
- ER  in  1  engine error; sampled only in BUSY.
- STOP  in  1  host abort; sampled in BUSY and HOLDOFF, and blocks acceptance in IDLE.
- RT  out  1  one-cycle pulse: retry started.
- HELP  out  1  sticky: retries exhausted.
- STATUS_VALID  out  1  status valid, 2 cycles.
- STATUS  out  2  00 ok, 01 stopped, 10 error, 11 timeout.
- INTERRUPT  out  1  completion interrupt pulse.

## Operation
- States: IDLE, LAUNCH, BUSY, HOLDOFF (3 cycles), REPORT (2 cycles).
- IDLE:
  - RDY=1.
  - REQ && !STOP: go to LAUNCH, clear retry_cnt and HELP, set first flag.
- LAUNCH (1 cycle):
  - START=1, ENABLE=1.
  - ACK=1 only on the first attempt.
  - Clear timer, go to BUSY.
- BUSY:
  - ENABLE=1, timer increments.
  - Priority STOP > ER > ENDD > timeout.
  - STOP: REPORT with 01.
  - ER with retry_cnt<MAX_RETRY: retry_cnt++, go to HOLDOFF.
  - ER with retry_cnt==MAX_RETRY: set HELP, REPORT with 10.
  - ENDD: REPORT with 00.
  - timer==TIMEOUT-1 with no other event: REPORT with 11.
- HOLDOFF:
  - ENABLE=0 for all 3 cycles; RT=1 in the first cycle only.
  - STOP in any cycle: REPORT with 01.
  - Otherwise go to LAUNCH, which issues no ACK.
- REPORT:
  - STATUS_VALID=1 with STATUS stable for both cycles.
  - INTERRUPT=1 in the first cycle only.
  - RDY=0, START=0, then go to IDLE.
- HELP stays set until the next accepted REQ. HELP and RT are never high together.
- REQ outside IDLE is ignored, and must not be dropped: it is accepted on return to IDLE.
- ENDD/ER outside BUSY are ignored.

## Timing
- All outputs are registered, decoded from the next state.
- Reset values: every output is 0, including RDY. State is IDLE.
- RDY=1 in the first cycle after rst falls.
- REQ sampled at edge k in IDLE: ACK=START=1 in cycle k+1; BUSY from cycle k+2.
- ENDD/STOP/ER sampled at edge k in BUSY: RDY=0 in cycle k+1 and at least one more cycle.
- Retry cost from ER to next START: 4 cycles (3 HOLDOFF + LAUNCH).
- RT in cycle k: ENABLE=0 in cycles k, k+1, k+2.
- INTERRUPT in cycle k: RDY=0 and START=0 in cycle k+1.
- Timeout: with ENDD arriving on the expiry edge, ENDD wins and STATUS=00.
- STOP together with ER: STATUS=01, retry_cnt unchanged, HELP unchanged.
- rst mid-operation: next cycle is IDLE with all outputs 0. No STATUS_VALID is emitted for the aborted operation.
- retry_cnt is 3 bits and saturates; no wrap.
- Timer only runs in BUSY; it cannot reach wrap because TIMEOUT ≤ 2^CNT_W-1.

## Configuration
- OP_SEQ_IRQ_EN
  - Defined: INTERRUPT pulses in the first REPORT cycle.
  - Undefined: INTERRUPT is tied 0 and the port remains. All other behaviour is identical.

## Structure
- Package op_seq_pkg holds:
  - state enum op_seq_state_e;
  - status code localparams ST_OK, ST_STOP, ST_ERR, ST_TMO (2-bit);
  - HOLDOFF_CYC=3 and REPORT_CYC=2.
- Sub-module op_seq_timer is natural: load/enable/expire counter with CNT_W and TIMEOUT parameters, used for the BUSY timeout.

## Test plan
- REQ=1 from IDLE, ENDD 5 cycles after START → ACK/START one cycle, REPORT STATUS=00 for 2 cycles, INTERRUPT 1 cycle (macro on), RDY=1 after.
- ER on each of 4 attempts (MAX_RETRY=3) → 3 RT pulses, each with ENABLE=0 for 3 cycles, ACK once, 4 STARTs, HELP=1, STATUS=10.
- No engine response with TIMEOUT=8 → REPORT STATUS=11 exactly 8 BUSY cycles after START.
- STOP and ER in the same BUSY cycle → STATUS=01, no RT. STOP in HOLDOFF cycle 2 → STATUS=01, no further START.
- rst asserted in BUSY → all outputs 0 next cycle, RDY=1 one cycle after rst falls, no STATUS_VALID.
- Macro off → same as scenario 1 with INTERRUPT constantly 0.

Source files
------------

// File: rtl/op_seq_pkg.sv
// Shared types and constants for the op_sequencer controller.
package op_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StBusy,
    StHoldoff,
    StReport
  } op_seq_state_e;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_STOP = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  localparam int unsigned HOLDOFF_CYC = 3;
  localparam int unsigned REPORT_CYC  = 2;

endpackage

// File: rtl/op_seq_timer.sv
// BUSY-phase timeout counter: cleared by load, counts while en, flags the last allowed cycle.
module op_seq_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/op_sequencer.sv
// Host-to-engine operation sequencer with error retry, holdoff, abort and timeout.
// Define OP_SEQ_IRQ_EN to enable the completion INTERRUPT pulse.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       REQ,
  output logic       ACK,
  output logic       RDY,
  output logic       START,
  output logic       ENABLE,
  input  logic       ENDD,
  input  logic       ER,
  input  logic       STOP,
  output logic       RT,
  output logic       HELP,
  output logic       STATUS_VALID,
  output logic [1:0] STATUS,
  output logic       INTERRUPT
);

  localparam logic [2:0] MAX_R     = 3'(MAX_RETRY);
  localparam logic [1:0] HOLD_LAST = 2'(HOLDOFF_CYC - 1);
  localparam logic [1:0] RPT_LAST  = 2'(REPORT_CYC - 1);

  op_seq_state_e state_q, state_d;
  logic [2:0] retry_q, retry_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] code_q, code_d;
  logic       help_q, help_d;
  logic       first_q, first_d;

  logic       tmr_load, tmr_en, tmr_expire;

  logic       ack_d, rdy_d, start_d, enable_d, rt_d, sv_d, irq_d;
  logic [1:0] status_d;
  logic       ack_q, rdy_q, start_q, enable_q, rt_q, sv_q, irq_q;
  logic [1:0] status_q;

  assign tmr_load = (state_q == StLaunch);
  assign tmr_en   = (state_q == StBusy);

  op_seq_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    phase_d = phase_q;
    code_d  = code_q;
    help_d  = help_q;
    first_d = first_q;

    unique case (state_q)
      StIdle: begin
        if (REQ && !STOP) begin
          state_d = StLaunch;
          retry_d = '0;
          help_d  = 1'b0;
          first_d = 1'b1;
        end
      end

      StLaunch: begin
        state_d = StBusy;
        first_d = 1'b0;
      end

      StBusy: begin
        if (STOP) begin
          state_d = StReport;
          phase_d = '0;
          code_d  = ST_STOP;
        end else if (ER) begin
          if (retry_q < MAX_R) begin
            // Saturating: never wraps back into the retry window.
            if (retry_q != 3'h7) begin
              retry_d = retry_q + 3'd1;
            end
            state_d = StHoldoff;
            phase_d = '0;
          end else begin
            help_d  = 1'b1;
            state_d = StReport;
            phase_d = '0;
            code_d  = ST_ERR;
          end
        end else if (ENDD) begin
          state_d = StReport;
          phase_d = '0;
          code_d  = ST_OK;
        end else if (tmr_expire) begin
          state_d = StReport;
          phase_d = '0;
          code_d  = ST_TMO;
        end
      end

      StHoldoff: begin
        if (STOP) begin
          state_d = StReport;
          phase_d = '0;
          code_d  = ST_STOP;
        end else if (phase_q == HOLD_LAST) begin
          state_d = StLaunch;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      StReport: begin
        if (phase_q == RPT_LAST) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of what the next state decodes to.
  always_comb begin
    rdy_d    = (state_d == StIdle);
    start_d  = (state_d == StLaunch);
    ack_d    = (state_d == StLaunch) && first_d;
    enable_d = (state_d == StLaunch) || (state_d == StBusy);
    rt_d     = (state_d == StHoldoff) && (state_q == StBusy);
    sv_d     = (state_d == StReport);
    status_d = sv_d ? code_d : ST_OK;
`ifdef OP_SEQ_IRQ_EN
    irq_d    = (state_d == StReport) && (state_q != StReport);
`else
    irq_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      retry_q  <= '0;
      phase_q  <= '0;
      code_q   <= ST_OK;
      help_q   <= 1'b0;
      first_q  <= 1'b0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      start_q  <= 1'b0;
      enable_q <= 1'b0;
      rt_q     <= 1'b0;
      sv_q     <= 1'b0;
      status_q <= ST_OK;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      phase_q  <= phase_d;
      code_q   <= code_d;
      help_q   <= help_d;
      first_q  <= first_d;
      ack_q    <= ack_d;
      rdy_q    <= rdy_d;
      start_q  <= start_d;
      enable_q <= enable_d;
      rt_q     <= rt_d;
      sv_q     <= sv_d;
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign ACK          = ack_q;
  assign RDY          = rdy_q;
  assign START        = start_q;
  assign ENABLE       = enable_q;
  assign RT           = rt_q;
  assign HELP         = help_q;
  assign STATUS_VALID = sv_q;
  assign STATUS       = status_q;
  assign INTERRUPT    = irq_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: per-cycle vector table through a scoreboard queue,
// plus a bounded hand-written timeout run.
module tb_op_sequencer;
  import op_seq_pkg::*;

  localparam int unsigned TMO = 8;

`ifdef OP_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req, endd, er, stop;
  logic       ack, rdy, start, enable, rt, help, sv, irq;
  logic [1:0] status;

  op_sequencer #(
    .MAX_RETRY (3),
    .TIMEOUT   (TMO),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .REQ          (req),
    .ACK          (ack),
    .RDY          (rdy),
    .START        (start),
    .ENABLE       (enable),
    .ENDD         (endd),
    .ER           (er),
    .STOP         (stop),
    .RT           (rt),
    .HELP         (help),
    .STATUS_VALID (sv),
    .STATUS       (status),
    .INTERRUPT    (irq)
  );

  typedef struct packed {
    logic       ack, rdy, start, enable, rt, help, sv;
    logic [1:0] st;
    logic       irq;
  } outs_t;

  typedef struct packed {
    logic  rst, req, endd, er, stop;
    outs_t exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic outs_t mk(input logic a, r, s, e, t, h, v, input logic [1:0] st,
                               input logic i);
    outs_t o;
    o.ack = a; o.rdy = r; o.start = s; o.enable = e; o.rt = t; o.help = h; o.sv = v;
    o.st = st; o.irq = i;
    return o;
  endfunction

  function automatic outs_t o_zero();
    return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endfunction
  function automatic outs_t o_idle(input logic h);
    return mk(0, 1, 0, 0, 0, h, 0, 2'b00, 0);
  endfunction
  function automatic outs_t o_launch(input logic a, input logic h);
    return mk(a, 0, 1, 1, 0, h, 0, 2'b00, 0);
  endfunction
  function automatic outs_t o_busy(input logic h);
    return mk(0, 0, 0, 1, 0, h, 0, 2'b00, 0);
  endfunction
  function automatic outs_t o_hold(input logic t, input logic h);
    return mk(0, 0, 0, 0, t, h, 0, 2'b00, 0);
  endfunction
  function automatic outs_t o_rpt(input logic first, input logic [1:0] st, input logic h);
    return mk(0, 0, 0, 0, 0, h, 1, st, first & IRQ_ON);
  endfunction

  function automatic outs_t sample();
    return mk(ack, rdy, start, enable, rt, help, sv, status, irq);
  endfunction

  task automatic add(input logic r, q, d, e, s, input outs_t x);
    vec_t v;
    v.rst = r; v.req = q; v.endd = d; v.er = e; v.stop = s; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input outs_t got, input outs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got ack%b rdy%b start%b en%b rt%b help%b sv%b st%b irq%b, required ack%b rdy%b start%b en%b rt%b help%b sv%b st%b irq%b",
               name, got.ack, got.rdy, got.start, got.enable, got.rt, got.help, got.sv,
               got.st, got.irq, exp.ack, exp.rdy, exp.start, exp.enable, exp.rt, exp.help,
               exp.sv, exp.st, exp.irq);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  int   start_cyc, sv_cyc;
  logic got_sv;
  logic [1:0] st_seen;

  initial begin
    rst = 1'b1; req = 1'b0; endd = 1'b0; er = 1'b0; stop = 1'b0;

    // Reset, then idle; STOP blocks acceptance in IDLE.
    add(1, 0, 0, 0, 0, o_zero());
    add(1, 0, 0, 0, 0, o_zero());
    add(0, 0, 0, 0, 0, o_idle(0));
    add(0, 1, 0, 0, 1, o_idle(0));

    // ENDD five cycles after START; ENDD during LAUNCH is ignored.
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    add(0, 0, 1, 0, 0, o_busy(0));
    repeat (4) add(0, 0, 0, 0, 0, o_busy(0));
    add(0, 0, 1, 0, 0, o_rpt(1, ST_OK, 0));
    add(0, 0, 0, 0, 0, o_rpt(0, ST_OK, 0));
    add(0, 0, 0, 0, 0, o_idle(0));

    // ER on all four attempts; ER during HOLDOFF is ignored.
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    add(0, 0, 0, 0, 0, o_busy(0));
    for (int a = 0; a < 3; a++) begin
      add(0, 0, 0, 1, 0, o_hold(1, 0));
      add(0, 0, 0, 1, 0, o_hold(0, 0));
      add(0, 0, 0, 0, 0, o_hold(0, 0));
      add(0, 0, 0, 0, 0, o_launch(0, 0));
      add(0, 0, 0, 0, 0, o_busy(0));
    end
    add(0, 0, 0, 1, 0, o_rpt(1, ST_ERR, 1));
    add(0, 0, 0, 0, 0, o_rpt(0, ST_ERR, 1));
    add(0, 0, 0, 0, 0, o_idle(1));

    // Timeout after TMO BUSY cycles; REQ held through REPORT is taken on return to IDLE.
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    repeat (TMO) add(0, 0, 0, 0, 0, o_busy(0));
    add(0, 1, 0, 0, 0, o_rpt(1, ST_TMO, 0));
    add(0, 1, 0, 0, 0, o_rpt(0, ST_TMO, 0));
    add(0, 1, 0, 0, 0, o_idle(0));
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    repeat (TMO) add(0, 0, 0, 0, 0, o_busy(0));
    // ENDD on the expiry cycle wins.
    add(0, 0, 1, 0, 0, o_rpt(1, ST_OK, 0));
    add(0, 0, 0, 0, 0, o_rpt(0, ST_OK, 0));
    add(0, 0, 0, 0, 0, o_idle(0));

    // STOP with ER in BUSY.
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    add(0, 0, 0, 0, 0, o_busy(0));
    add(0, 0, 0, 1, 1, o_rpt(1, ST_STOP, 0));
    add(0, 0, 0, 0, 0, o_rpt(0, ST_STOP, 0));
    add(0, 0, 0, 0, 0, o_idle(0));

    // STOP in HOLDOFF cycle 2: no further START.
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    add(0, 0, 0, 0, 0, o_busy(0));
    add(0, 0, 0, 1, 0, o_hold(1, 0));
    add(0, 0, 0, 0, 0, o_hold(0, 0));
    add(0, 0, 0, 0, 1, o_rpt(1, ST_STOP, 0));
    add(0, 0, 0, 0, 0, o_rpt(0, ST_STOP, 0));
    add(0, 0, 0, 0, 0, o_idle(0));
    add(0, 0, 0, 0, 0, o_idle(0));

    // Reset mid-BUSY: outputs clear, no status for the aborted operation.
    add(0, 1, 0, 0, 0, o_launch(1, 0));
    add(0, 0, 0, 0, 0, o_busy(0));
    add(0, 0, 0, 0, 0, o_busy(0));
    add(1, 0, 0, 0, 0, o_zero());
    add(0, 0, 0, 0, 0, o_idle(0));
    add(0, 0, 0, 0, 0, o_idle(0));
    add(0, 0, 0, 0, 0, o_idle(0));

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      req  = vecs[i].req;
      endd = vecs[i].endd;
      er   = vecs[i].er;
      stop = vecs[i].stop;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), sample(), sb_q.pop_front());
    end

    // Bounded wait for a timeout completion with a silent engine.
    req = 1'b1; endd = 1'b0; er = 1'b0; stop = 1'b0;
    start_cyc = -1; sv_cyc = -1; got_sv = 1'b0; st_seen = 2'b00;
    for (int c = 0; c < 60 && !got_sv; c++) begin
      @(posedge clk);
      #1;
      if (start && start_cyc < 0) start_cyc = c;
      if (ack) req = 1'b0;
      if (sv) begin
        got_sv  = 1'b1;
        sv_cyc  = c;
        st_seen = status;
      end
    end
    chk_int("tmo_seen", int'(got_sv), 1);
    chk_int("tmo_latency", sv_cyc - start_cyc, int'(TMO) + 1);
    chk_int("tmo_status", int'(st_seen), int'(ST_TMO));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
